// File: rtl/rfa_pkg.sv
// Shared constants for reg_file_arbiter: state encoding and requester indices.
package rfa_pkg;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_ACCESS = 2'b01;
  localparam logic [1:0] ST_RDWAIT = 2'b10;

  localparam int unsigned REQ_NUM = 2;
  localparam logic        REQ0    = 1'b0;
  localparam logic        REQ1    = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    ACCESS = ST_ACCESS,
    RDWAIT = ST_RDWAIT
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin winner select with a registered priority pointer.
module rr_arb2
  import rfa_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [REQ_NUM-1:0] req,
  input  logic               advance,
  input  logic               owner,
  output logic               winner_c,
  output logic               any_c
);

  logic ptr;

  // Pointer only breaks ties; a lone requester always wins.
  always_comb begin
    any_c    = |req;
    winner_c = REQ0;
    if (req[REQ0] && req[REQ1]) begin
      winner_c = ptr;
    end else if (req[REQ1]) begin
      winner_c = REQ1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= REQ0;
    end else if (advance) begin
      ptr <= ~owner;
    end
  end

endmodule

// File: rtl/reg_file_arbiter.sv
// Round-robin sharing of one single-port register file between two requesters.
// Optional write protection of low addresses against Requester 1: RFA_WRITE_PROTECT_EN.
module reg_file_arbiter
  import rfa_pkg::*;
#(
  parameter int unsigned REG_WIDTH  = 16,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned PROT_ADDR  = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Req0,
  input  logic                  Req1,
  input  logic                  Wr0,
  input  logic                  Wr1,
  input  logic [ADDR_WIDTH-1:0] Addr0,
  input  logic [ADDR_WIDTH-1:0] Addr1,
  input  logic [REG_WIDTH-1:0]  WData0,
  input  logic [REG_WIDTH-1:0]  WData1,
  output logic                  Gnt0,
  output logic                  Gnt1,
  output logic [REG_WIDTH-1:0]  RData0,
  output logic [REG_WIDTH-1:0]  RData1,
  output logic                  RValid0,
  output logic                  RValid1,
  output logic                  RF_WrEn,
  output logic                  RF_RdEn,
  output logic [ADDR_WIDTH-1:0] RF_Address,
  output logic [REG_WIDTH-1:0]  RF_WrData,
  input  logic [REG_WIDTH-1:0]  RF_RdData
`ifdef RFA_WRITE_PROTECT_EN
  ,
  output logic                  WrErr1
`endif
);

  if (PROT_ADDR > (32'd1 << ADDR_WIDTH)) begin : g_prot_range
    $error("PROT_ADDR exceeds the register address space");
  end

  state_t                  state_q, state_d;
  logic                    owner_q, owner_d;
  logic                    win_c, any_c, advance_c;
  logic                    sel_wr_c;
  logic [ADDR_WIDTH-1:0]   sel_addr_c;
  logic [REG_WIDTH-1:0]    sel_wdata_c;
  logic [REQ_NUM-1:0]      gnt_d, rvalid_d;
  logic                    wr_en_d, rd_en_d;
  logic [ADDR_WIDTH-1:0]   addr_d;
  logic [REG_WIDTH-1:0]    wdata_d, rdata0_d, rdata1_d;
`ifdef RFA_WRITE_PROTECT_EN
  logic                    prot_c, wr_err_d;
  assign prot_c = (win_c == REQ1) && Wr1 && (32'(Addr1) < PROT_ADDR);
`endif

  rr_arb2 u_arb (
    .clk      (CLK),
    .rst_n    (RST),
    .req      ({Req1, Req0}),
    .advance  (advance_c),
    .owner    (owner_q),
    .winner_c (win_c),
    .any_c    (any_c)
  );

  assign advance_c   = (state_q == ACCESS);
  assign sel_wr_c    = (win_c == REQ1) ? Wr1    : Wr0;
  assign sel_addr_c  = (win_c == REQ1) ? Addr1  : Addr0;
  assign sel_wdata_c = (win_c == REQ1) ? WData1 : WData0;

  // Next-state and next-output values; every output below is registered.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    gnt_d    = '0;
    rvalid_d = '0;
    wr_en_d  = 1'b0;
    rd_en_d  = 1'b0;
    addr_d   = RF_Address;
    wdata_d  = RF_WrData;
    rdata0_d = RData0;
    rdata1_d = RData1;
`ifdef RFA_WRITE_PROTECT_EN
    wr_err_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (any_c) begin
          state_d       = ACCESS;
          owner_d       = win_c;
          gnt_d[win_c]  = 1'b1;
          addr_d        = sel_addr_c;
          wdata_d       = sel_wdata_c;
          wr_en_d       = sel_wr_c;
          rd_en_d       = !sel_wr_c;
`ifdef RFA_WRITE_PROTECT_EN
          if (prot_c) begin
            wr_en_d  = 1'b0;
            wr_err_d = 1'b1;
          end
`endif
        end
      end
      ACCESS: begin
        state_d = RF_RdEn ? RDWAIT : IDLE;
      end
      RDWAIT: begin
        state_d           = IDLE;
        rvalid_d[owner_q] = 1'b1;
        if (owner_q == REQ1) begin
          rdata1_d = RF_RdData;
        end else begin
          rdata0_d = RF_RdData;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      owner_q    <= REQ0;
      Gnt0       <= 1'b0;
      Gnt1       <= 1'b0;
      RValid0    <= 1'b0;
      RValid1    <= 1'b0;
      RData0     <= '0;
      RData1     <= '0;
      RF_WrEn    <= 1'b0;
      RF_RdEn    <= 1'b0;
      RF_Address <= '0;
      RF_WrData  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      Gnt0       <= gnt_d[REQ0];
      Gnt1       <= gnt_d[REQ1];
      RValid0    <= rvalid_d[REQ0];
      RValid1    <= rvalid_d[REQ1];
      RData0     <= rdata0_d;
      RData1     <= rdata1_d;
      RF_WrEn    <= wr_en_d;
      RF_RdEn    <= rd_en_d;
      RF_Address <= addr_d;
      RF_WrData  <= wdata_d;
    end
  end

`ifdef RFA_WRITE_PROTECT_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      WrErr1 <= 1'b0;
    end else begin
      WrErr1 <= wr_err_d;
    end
  end
`endif

endmodule

// File: tb/tb_reg_file_arbiter.sv
// Self-checking bench for reg_file_arbiter: directed scenarios plus randomized traffic
// against a transaction-level model. Build with RFA_WRITE_PROTECT_EN to cover protection.
`timescale 1ns/1ps
module tb_reg_file_arbiter;

  localparam int unsigned RW = 16;
  localparam int unsigned AW = 3;
  localparam int unsigned PA = 2;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          Req0 = 1'b0, Req1 = 1'b0, Wr0 = 1'b0, Wr1 = 1'b0;
  logic [AW-1:0] Addr0 = '0, Addr1 = '0;
  logic [RW-1:0] WData0 = '0, WData1 = '0;
  logic          Gnt0, Gnt1, RValid0, RValid1, RF_WrEn, RF_RdEn;
  logic [RW-1:0] RData0, RData1, RF_WrData, RF_RdData;
  logic [AW-1:0] RF_Address;
  logic          werr_obs;

`ifdef RFA_WRITE_PROTECT_EN
  logic WrErr1;
  assign werr_obs = WrErr1;
`else
  assign werr_obs = 1'b0;
`endif

  reg_file_arbiter #(.REG_WIDTH(RW), .ADDR_WIDTH(AW), .PROT_ADDR(PA)) dut (
    .CLK(CLK), .RST(RST),
    .Req0(Req0), .Req1(Req1), .Wr0(Wr0), .Wr1(Wr1),
    .Addr0(Addr0), .Addr1(Addr1), .WData0(WData0), .WData1(WData1),
    .Gnt0(Gnt0), .Gnt1(Gnt1), .RData0(RData0), .RData1(RData1),
    .RValid0(RValid0), .RValid1(RValid1),
    .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn), .RF_Address(RF_Address),
    .RF_WrData(RF_WrData), .RF_RdData(RF_RdData)
`ifdef RFA_WRITE_PROTECT_EN
    , .WrErr1(WrErr1)
`endif
  );

  always #5 CLK = ~CLK;

  // Register file with registered read port.
  logic [RW-1:0] rf_mem [8];
  always @(posedge CLK) begin
    if (RF_WrEn) rf_mem[RF_Address] <= RF_WrData;
    if (RF_RdEn) RF_RdData <= rf_mem[RF_Address];
  end

  // Transaction-level reference: when the arbiter is free it picks a winner, schedules
  // the grant for the next cycle and the read return two cycles after the grant.
  int            tests = 0, fails = 0, n = 0, free_at = 0;
  logic          ptr;
  logic [RW-1:0] ref_mem [8];
  logic [1:0]    rv_slot [8];
  logic [RW-1:0] rvd_slot [8];
  logic [1:0]    e_gnt, e_rv;
  logic          e_wren, e_rden, e_werr;
  logic [AW-1:0] e_addr;
  logic [RW-1:0] e_wdata, e_rd0, e_rd1;

  function automatic logic [6:0] obs_ctl();
    return {Gnt0, Gnt1, RF_WrEn, RF_RdEn, RValid0, RValid1, werr_obs};
  endfunction

  function automatic logic [6:0] exp_ctl();
    return {e_gnt[0], e_gnt[1], e_wren, e_rden, e_rv[0], e_rv[1], e_werr};
  endfunction

  task automatic model_reset();
    ptr = 1'b0; free_at = 0;
    e_gnt = '0; e_rv = '0; e_wren = 1'b0; e_rden = 1'b0; e_werr = 1'b0;
    e_addr = '0; e_wdata = '0; e_rd0 = '0; e_rd1 = '0;
    for (int i = 0; i < 8; i++) begin rv_slot[i] = '0; rvd_slot[i] = '0; end
  endtask

  task automatic model_edge();
    logic w, wr, prot;
    logic [AW-1:0] a;
    logic [RW-1:0] d;
    logic [2:0] s0, s2;
    n++;
    s0 = 3'(n); s2 = 3'(n + 2);
    e_gnt = '0; e_wren = 1'b0; e_rden = 1'b0; e_werr = 1'b0;
    e_rv = rv_slot[s0]; rv_slot[s0] = '0;
    if (e_rv[0]) e_rd0 = rvd_slot[s0];
    if (e_rv[1]) e_rd1 = rvd_slot[s0];
    if (RST && n >= free_at && (Req0 || Req1)) begin
      w = (Req0 && Req1) ? ptr : Req1;
      wr = w ? Wr1 : Wr0; a = w ? Addr1 : Addr0; d = w ? WData1 : WData0;
      ptr = ~w;
      e_gnt[w] = 1'b1; e_addr = a; e_wdata = d;
      if (wr) begin
        free_at = n + 2;
        prot = 1'b0;
`ifdef RFA_WRITE_PROTECT_EN
        prot = w && (32'(a) < PA);
`endif
        if (prot) e_werr = 1'b1;
        else begin e_wren = 1'b1; ref_mem[a] = d; end
      end else begin
        free_at = n + 3;
        e_rden = 1'b1;
        rv_slot[s2][w] = 1'b1;
        rvd_slot[s2] = ref_mem[a];
      end
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic drive_req(input logic i, input logic r, input logic w,
                           input logic [AW-1:0] a, input logic [RW-1:0] d);
    if (i) begin Req1 = r; Wr1 = w; Addr1 = a; WData1 = d; end
    else   begin Req0 = r; Wr0 = w; Addr0 = a; WData0 = d; end
  endtask

  task automatic test_reset();
    #2 RST = 1'b0;
    model_reset();
    #1;
    tests++;
    if ({obs_ctl(), RData0, RData1, RF_Address, RF_WrData} !== '0) begin
      fails++;
      $display("FAIL reset_outputs got=%h exp=0", {obs_ctl(), RData0, RData1, RF_Address, RF_WrData});
    end
    tick(); tick();
    RST = 1'b1;
  endtask

  task automatic test_single_write();
    drive_req(1'b0, 1'b1, 1'b1, 3'd5, 16'hA5A5);
    tick();
    tests++;
    if (obs_ctl() !== exp_ctl() || obs_ctl() !== 7'b1010000) begin
      fails++; $display("FAIL write_ctl got=%b exp=%b", obs_ctl(), exp_ctl());
    end
    tests++;
    if ({RF_Address, RF_WrData} !== {3'd5, 16'hA5A5}) begin
      fails++; $display("FAIL write_bus got=%h exp=%h", {RF_Address, RF_WrData}, {3'd5, 16'hA5A5});
    end
    drive_req(1'b0, 1'b0, 1'b0, '0, '0);
    repeat (2) begin
      tick();
      tests++;
      if (obs_ctl() !== exp_ctl()) begin
        fails++; $display("FAIL write_idle got=%b exp=%b", obs_ctl(), exp_ctl());
      end
    end
  endtask

  task automatic test_read_back();
    drive_req(1'b1, 1'b1, 1'b0, 3'd5, '0);
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 1) drive_req(1'b1, 1'b0, 1'b0, '0, '0);
      tests++;
      if (obs_ctl() !== exp_ctl()) begin
        fails++; $display("FAIL readback_ctl cyc=%0d got=%b exp=%b", c, obs_ctl(), exp_ctl());
      end
      if (c == 3) begin
        tests++;
        if (RValid1 !== 1'b1 || RData1 !== 16'hA5A5) begin
          fails++; $display("FAIL readback_data got=%b/%h exp=1/a5a5", RValid1, RData1);
        end
      end
    end
  endtask

  task automatic test_contention();
    int gq[$];
    drive_req(1'b0, 1'b1, 1'b0, 3'd1, '0);
    drive_req(1'b1, 1'b1, 1'b0, 3'd2, '0);
    for (int c = 0; c < 15; c++) begin
      tick();
      if (c == 11) begin
        drive_req(1'b0, 1'b0, 1'b0, '0, '0);
        drive_req(1'b1, 1'b0, 1'b0, '0, '0);
      end
      if (Gnt0) gq.push_back(0);
      if (Gnt1) gq.push_back(1);
      tests++;
      if (obs_ctl() !== exp_ctl() || {RData0, RData1} !== {e_rd0, e_rd1} || (RF_WrEn && RF_RdEn)) begin
        fails++;
        $display("FAIL contention cyc=%0d got=%b/%h exp=%b/%h", c, obs_ctl(), {RData0, RData1},
                 exp_ctl(), {e_rd0, e_rd1});
      end
    end
    tests++;
    if (gq.size() != 4) begin
      fails++; $display("FAIL contention_count got=%0d exp=4", gq.size());
    end
    foreach (gq[i]) begin
      tests++;
      if (gq[i] != i % 2) begin
        fails++; $display("FAIL contention_order idx=%0d got=%0d exp=%0d", i, gq[i], i % 2);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    drive_req(1'b0, 1'b1, 1'b0, 3'd3, '0);
    tick();
    drive_req(1'b0, 1'b0, 1'b0, '0, '0);
    tick();
    #2 RST = 1'b0;
    model_reset();
    #1;
    tests++;
    if ({obs_ctl(), RData0, RData1, RF_Address, RF_WrData} !== '0) begin
      fails++;
      $display("FAIL midread_reset got=%h exp=0", {obs_ctl(), RData0, RData1, RF_Address, RF_WrData});
    end
    tick(); tick();
    RST = 1'b1;
    repeat (3) begin
      tick();
      tests++;
      if (obs_ctl() !== exp_ctl() || RValid0 !== 1'b0) begin
        fails++; $display("FAIL midread_after got=%b exp=%b", obs_ctl(), exp_ctl());
      end
    end
    drive_req(1'b0, 1'b1, 1'b1, 3'd6, RW'($urandom));
    drive_req(1'b1, 1'b1, 1'b1, 3'd7, RW'($urandom));
    for (int c = 0; c < 4; c++) begin
      tick();
      if (c == 0) begin
        tests++;
        if (Gnt0 !== 1'b1 || Gnt1 !== 1'b0) begin
          fails++; $display("FAIL midread_ptr got=%b%b exp=10", Gnt0, Gnt1);
        end
        drive_req(1'b0, 1'b0, 1'b0, '0, '0);
      end
      if (c == 2) drive_req(1'b1, 1'b0, 1'b0, '0, '0);
      tests++;
      if (obs_ctl() !== exp_ctl() || {RF_Address, RF_WrData} !== {e_addr, e_wdata}) begin
        fails++; $display("FAIL midread_regrant cyc=%0d got=%b exp=%b", c, obs_ctl(), exp_ctl());
      end
    end
  endtask

  task automatic test_withdraw();
    drive_req(1'b0, 1'b1, 1'b1, 3'd4, RW'($urandom));
    tick();
    drive_req(1'b0, 1'b0, 1'b0, '0, '0);
    drive_req(1'b1, 1'b1, 1'b0, 3'd6, '0);
    tick();
    drive_req(1'b1, 1'b0, 1'b0, '0, '0);
    repeat (3) begin
      tick();
      tests++;
      if (obs_ctl() !== exp_ctl() || Gnt1 !== 1'b0 || RF_RdEn !== 1'b0) begin
        fails++; $display("FAIL withdraw got=%b exp=%b", obs_ctl(), exp_ctl());
      end
    end
  endtask

`ifdef RFA_WRITE_PROTECT_EN
  task automatic test_write_protect();
    drive_req(1'b1, 1'b1, 1'b1, 3'd1, 16'h1111);
    tick();
    drive_req(1'b1, 1'b0, 1'b0, '0, '0);
    tests++;
    if ({Gnt1, WrErr1, RF_WrEn} !== 3'b110 || obs_ctl() !== exp_ctl()) begin
      fails++; $display("FAIL protect_low got=%b exp=110", {Gnt1, WrErr1, RF_WrEn});
    end
    tick();
    drive_req(1'b1, 1'b1, 1'b1, 3'd3, 16'h3333);
    tick();
    drive_req(1'b1, 1'b0, 1'b0, '0, '0);
    tests++;
    if ({Gnt1, WrErr1, RF_WrEn} !== 3'b101 || obs_ctl() !== exp_ctl()) begin
      fails++; $display("FAIL protect_high got=%b exp=101", {Gnt1, WrErr1, RF_WrEn});
    end
    tick();
  endtask
`endif

  task automatic test_random();
    logic [1:0] pend = '0;
    for (int c = 0; c < 400; c++) begin
      tick();
      tests++;
      if (obs_ctl() !== exp_ctl() || (RF_WrEn && RF_RdEn)) begin
        fails++; $display("FAIL random_ctl cyc=%0d got=%b exp=%b", c, obs_ctl(), exp_ctl());
      end
      tests++;
      if ({RF_Address, RF_WrData} !== {e_addr, e_wdata}) begin
        fails++; $display("FAIL random_bus cyc=%0d got=%h exp=%h", c, {RF_Address, RF_WrData}, {e_addr, e_wdata});
      end
      tests++;
      if ({RData0, RData1} !== {e_rd0, e_rd1}) begin
        fails++; $display("FAIL random_rdata cyc=%0d got=%h exp=%h", c, {RData0, RData1}, {e_rd0, e_rd1});
      end
      for (int i = 0; i < 2; i++) begin
        if (e_gnt[i]) pend[i] = 1'b0;
        if (pend[i] && $urandom_range(0, 19) == 0) begin
          pend[i] = 1'b0;
          drive_req(1'(i), 1'b0, 1'b0, '0, '0);
        end else if (!pend[i]) begin
          if ($urandom_range(0, 1) == 1) begin
            pend[i] = 1'b1;
            drive_req(1'(i), 1'b1, 1'($urandom), AW'($urandom), RW'($urandom));
          end else begin
            drive_req(1'(i), 1'b0, 1'b0, '0, '0);
          end
        end
      end
    end
    drive_req(1'b0, 1'b0, 1'b0, '0, '0);
    drive_req(1'b1, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      logic [RW-1:0] v;
      v = RW'($urandom);
      rf_mem[i] = v;
      ref_mem[i] = v;
    end
    model_reset();
    test_reset();
    test_single_write();
    test_read_back();
    test_contention();
    test_reset_mid_read();
    test_withdraw();
`ifdef RFA_WRITE_PROTECT_EN
    test_write_protect();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
